// File: rtl/brief_pkg.sv
// Shared types and constants for the BRIEF descriptor collector.
package brief_pkg;

    localparam logic [3:0] TAG_KP  = 4'hD;
    localparam logic [3:0] TAG_SOF = 4'hA;
    localparam logic [3:0] TAG_EOF = 4'hE;
    localparam int unsigned KP_WORDS = 10;

    typedef struct packed {
        logic [9:0]   x;
        logic [9:0]   y;
        logic [7:0]   score;
        logic [15:0]  depth;
        logic [255:0] desc;
    } kp_rec_t;

    typedef struct packed {
        logic kp;
        logic eof;
        logic sof;
    } entry_flags_t;

    typedef struct packed {
        entry_flags_t flags;
        kp_rec_t      rec;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KP,
        S_EOF,
        S_SOF
    } state_t;

    // Word order inside an entry: keypoint words, then EOF, then SOF.
    function automatic state_t first_state(input entry_flags_t f);
        if (f.kp) begin
            return S_KP;
        end else if (f.eof) begin
            return S_EOF;
        end
        return S_SOF;
    endfunction

endpackage

// File: rtl/brief_desc_fifo.sv
// Synchronous FIFO of collector entries; exposes head, the entry behind it and the occupancy.
module brief_desc_fifo
    import brief_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  entry_t                         wr_data,
    input  logic                           rd_en,
    output entry_t                         head,
    output entry_t                         head_next,
    output logic [$clog2(DEPTH+1)-1:0]     used
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_inc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign rd_ptr_inc = ptr_inc(rd_ptr_q);
    assign head       = mem[rd_ptr_q];
    assign head_next  = mem[rd_ptr_inc];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used     <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_q <= rd_ptr_inc;
            case ({wr_en, rd_en})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/brief_desc_collector.sv
// BRIEF descriptor collector: buffers keypoint/marker events and serialises them to 32-bit words.
// Define BRIEF_COLLECT_DROP_CNT_EN to report per-frame dropped keypoints in EOF bits [27:20].
module brief_desc_collector
    import brief_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 20
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_pixel_valid,
    input  logic         i_flag,
    input  logic [9:0]   i_coor_x,
    input  logic [9:0]   i_coor_y,
    input  logic [7:0]   i_score,
    input  logic [15:0]  i_depth,
    input  logic [255:0] i_descriptor,
    input  logic         i_start,
    input  logic         i_end,
    output logic [31:0]  o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_last,
    output logic         o_overflow
);
    localparam int unsigned UW = $clog2(DEPTH + 1);
    localparam logic [UW-1:0] USED_RSV = UW'(DEPTH - 1);
    localparam logic [3:0] LAST_IDX = 4'(KP_WORDS - 1);

    entry_t head, head_next, wr_entry, src;
    logic [UW-1:0] used;
    logic wr_en, pop, evt, marker, drop_kp, lose;
    logic accept, load, done;
    state_t state_q, state_d, nxt_state;
    logic [3:0] idx_q, idx_d, nxt_idx;
    logic [CNT_W-1:0] kp_cnt_q, kp_cnt_d;
    logic [7:0] drop_field;
    logic [19:0] cnt20;
    logic [2:0] chunk;
    logic [31:0] word;

    brief_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (wr_en),
        .wr_data   (wr_entry),
        .rd_en     (pop),
        .head      (head),
        .head_next (head_next),
        .used      (used)
    );

    // Capture policy: the last free slot is reserved for entries carrying a marker.
    always_comb begin
        evt    = i_pixel_valid & (i_flag | i_start | i_end);
        marker = i_start | i_end;
        wr_entry.flags.kp  = i_flag;
        wr_entry.flags.eof = i_end;
        wr_entry.flags.sof = i_start;
        wr_entry.rec.x     = i_coor_x;
        wr_entry.rec.y     = i_coor_y;
        wr_entry.rec.score = i_score;
        wr_entry.rec.depth = i_depth;
        wr_entry.rec.desc  = i_descriptor;
        wr_en   = 1'b0;
        drop_kp = 1'b0;
        lose    = 1'b0;
        if (evt) begin
            if (used < USED_RSV) begin
                wr_en = 1'b1;
            end else if (used == USED_RSV && marker) begin
                wr_en             = 1'b1;
                wr_entry.flags.kp = 1'b0;
                drop_kp           = i_flag;
            end else begin
                drop_kp = i_flag;
                lose    = 1'b1;
            end
        end
        lose = lose | drop_kp;
    end

    assign accept = o_valid & i_ready;
    assign load   = ~o_valid | accept;

    always_comb begin
        kp_cnt_d = kp_cnt_q;
        if (accept && state_q == S_SOF) begin
            kp_cnt_d = '0;
        end else if (accept && state_q == S_KP && idx_q == LAST_IDX && kp_cnt_q != '1) begin
            kp_cnt_d = kp_cnt_q + CNT_W'(1);
        end
    end

`ifdef BRIEF_COLLECT_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = (accept && state_q == S_SOF) ? 8'h00 : drop_cnt_q;
        if (drop_kp && drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'h01;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) drop_cnt_q <= 8'h00;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_field = drop_cnt_d;
`else
    assign drop_field = 8'h00;
`endif

    // Successor word within the current entry; done marks its final word.
    always_comb begin
        nxt_state = S_IDLE;
        nxt_idx   = '0;
        done      = 1'b0;
        unique case (state_q)
            S_KP: begin
                if (idx_q != LAST_IDX) begin
                    nxt_state = S_KP;
                    nxt_idx   = idx_q + 4'd1;
                end else if (head.flags.eof) begin
                    nxt_state = S_EOF;
                end else if (head.flags.sof) begin
                    nxt_state = S_SOF;
                end else begin
                    done = 1'b1;
                end
            end
            S_EOF: begin
                if (head.flags.sof) nxt_state = S_SOF;
                else                done      = 1'b1;
            end
            S_SOF:   done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src     = head;
        if (state_q == S_IDLE) begin
            idx_d = '0;
            if (used != '0) state_d = first_state(head.flags);
        end else if (accept) begin
            idx_d = '0;
            if (!done) begin
                state_d = nxt_state;
                idx_d   = nxt_idx;
            end else if (used > UW'(1)) begin
                // Next entry starts without a bubble while the current one pops.
                src     = head_next;
                state_d = first_state(head_next.flags);
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    assign pop = accept & done;

    always_comb begin
        cnt20 = 20'(kp_cnt_d);
        chunk = 3'(4'd9 - idx_d);
        word  = 32'h0;
        unique case (state_d)
            S_KP: begin
                if (idx_d == 4'd0)      word = {TAG_KP, src.rec.score, src.rec.y, src.rec.x};
                else if (idx_d == 4'd1) word = {16'h0000, src.rec.depth};
                else                    word = src.rec.desc[{chunk, 5'b0} +: 32];
            end
            S_EOF:   word = {TAG_EOF, drop_field, cnt20};
            S_SOF:   word = {TAG_SOF, 28'h0};
            default: word = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_overflow <= 1'b0;
            kp_cnt_q   <= '0;
        end else begin
            kp_cnt_q <= kp_cnt_d;
            if (lose) o_overflow <= 1'b1;
            if (load) begin
                state_q <= state_d;
                idx_q   <= idx_d;
                o_data  <= word;
                o_valid <= (state_d != S_IDLE);
                o_last  <= (state_d == S_EOF);
            end
        end
    end

endmodule

// File: tb/tb_brief_desc_collector.sv
// Randomised self-checking bench for brief_desc_collector against a word-queue reference model.
module tb_brief_desc_collector;
    localparam int unsigned DEPTH = 4;
    localparam logic [255:0] PATTERN = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D,
                                        32'h0F1E2D3C, 32'h4B5A6978, 32'h13572468, 32'hFEDCBA98};

    logic clk = 1'b0;
    logic rst, pixel_valid, flag, start, frame_end, ready;
    logic [9:0] coor_x, coor_y;
    logic [7:0] score;
    logic [15:0] depth;
    logic [255:0] descriptor;
    logic [31:0] data;
    logic valid, last, overflow;

    always #5 clk = ~clk;

    brief_desc_collector #(.DEPTH(DEPTH), .CNT_W(20)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pixel_valid (pixel_valid),
        .i_flag        (flag),
        .i_coor_x      (coor_x),
        .i_coor_y      (coor_y),
        .i_score       (score),
        .i_depth       (depth),
        .i_descriptor  (descriptor),
        .i_start       (start),
        .i_end         (frame_end),
        .o_data        (data),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_last        (last),
        .o_overflow    (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected {last, word} stream and remaining word count per stored entry.
    logic [32:0] exp_q[$];
    int ent_q[$];
    logic m_ovf = 1'b0;
    int m_kp = 0;
    int m_drop = 0;
    int m_acc = 0;
    logic prev_stall = 1'b0;
    logic [32:0] prev_word = '0;
    logic rand_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_entry(input logic kp, input logic eof, input logic sof);
        int n = 0;
        logic [255:0] sh;
        logic [7:0] dfield;
        if (kp) begin
            exp_q.push_back({1'b0, 4'hD, score, coor_y, coor_x});
            exp_q.push_back({1'b0, 16'h0000, depth});
            for (int i = 0; i < 8; i++) begin
                sh = descriptor >> (32 * (7 - i));
                exp_q.push_back({1'b0, sh[31:0]});
            end
            n += 10;
            m_kp++;
        end
        if (eof) begin
`ifdef BRIEF_COLLECT_DROP_CNT_EN
            dfield = (m_drop > 255) ? 8'hFF : 8'(m_drop);
`else
            dfield = 8'h00;
`endif
            exp_q.push_back({1'b1, 4'hE, dfield, 20'(m_kp)});
            n++;
        end
        if (sof) begin
            exp_q.push_back({1'b0, 32'hA0000000});
            m_kp = 0;
            n++;
        end
        ent_q.push_back(n);
    endtask

    // Runs just before each rising edge with the inputs that edge will sample.
    task automatic model_step();
        int used;
        logic [32:0] w;
        logic kp;
        if (rst) begin
            exp_q.delete();
            ent_q.delete();
            m_ovf = 1'b0;
            m_kp = 0;
            m_drop = 0;
            prev_stall = 1'b0;
            return;
        end
        used = ent_q.size();
        check_eq("overflow", overflow, m_ovf);
        if (exp_q.size() == 0) check_eq("idle_valid", valid, 1'b0);
        if (prev_stall) check_eq("stall_hold", {last, data}, prev_word);
        if (valid && ready && exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check_eq("word", {last, data}, w);
            m_acc++;
            ent_q[0] = ent_q[0] - 1;
            if (ent_q[0] == 0) void'(ent_q.pop_front());
            if (w == {1'b0, 32'hA0000000}) m_drop = 0;
        end
        prev_stall = valid & ~ready;
        prev_word  = {last, data};
        if (pixel_valid && (flag || start || frame_end)) begin
            kp = flag;
            if (used >= DEPTH || (used == DEPTH - 1 && !(start || frame_end))) begin
                m_ovf = 1'b1;
                if (flag) m_drop++;
            end else begin
                if (used == DEPTH - 1 && kp) begin
                    kp = 1'b0;
                    m_ovf = 1'b1;
                    m_drop++;
                end
                push_entry(kp, frame_end, start);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic pv, input logic f, input logic s, input logic e,
                        input logic rnd);
        pixel_valid = pv;
        flag = f;
        start = s;
        frame_end = e;
        if (rnd) begin
            coor_x = 10'($urandom);
            coor_y = 10'($urandom);
            score  = 8'($urandom);
            depth  = 16'($urandom);
            for (int i = 0; i < 8; i++) descriptor[32*i +: 32] = $urandom;
        end else begin
            coor_x = 10'd5;
            coor_y = 10'd7;
            score  = 8'd9;
            depth  = 16'h1234;
            descriptor = PATTERN;
        end
        tick();
        pixel_valid = 1'b0;
        flag = 1'b0;
        start = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic wait_room();
        int n = 0;
        while (ent_q.size() >= DEPTH - 1 && n < 1000) begin
            tick();
            n++;
        end
        check_eq("room_timeout", n < 1000, 1'b1);
    endtask

    task automatic drain(input string tag, output int cycles);
        int n = 0;
        while ((exp_q.size() != 0 || valid) && n < 2000) begin
            tick();
            n++;
        end
        cycles = n;
        check_eq({tag, "_drain"}, n < 2000, 1'b1);
    endtask

    task automatic frame3(input logic gated);
        if (gated) wait_room();
        send(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (gated) wait_room();
            send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (gated) wait_room();
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acc0;
        int n;
        rst = 1'b1;
        pixel_valid = 1'b0;
        flag = 1'b0;
        start = 1'b0;
        frame_end = 1'b0;
        ready = 1'b1;
        coor_x = '0;
        coor_y = '0;
        score = '0;
        depth = '0;
        descriptor = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_data", data, 32'h0);
        check_eq("rst_last", last, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);

        // Directed frame, i_ready high: latency, exact words, sustained rate.
        send(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("lat_edge_n", valid, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lat_edge_n1", valid, 1'b1);
        check_eq("lat_sof_word", data, 32'hA0000000);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("frame", cyc);
        check_eq("rate_cycles", cyc, 29);

        // Same frame with a 50% random sink.
        rand_ready = 1'b1;
        frame3(1'b1);
        drain("stall_frame", cyc);
        rand_ready = 1'b0;
        ready = 1'b1;

        // Keypoint, end and start in one cycle.
        send(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_room();
        send(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_room();
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain("combo", cyc);

        // Overflow with a stalled sink; EOF still lands in the reserved slot.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("ovf_set", overflow, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ovf_entries", ent_q.size(), 4);
        ready = 1'b1;
        drain("ovf", cyc);
        check_eq("ovf_sticky", overflow, 1'b1);

        // Reset while w4 of a record is on the output.
        send(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        acc0 = m_acc;
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (m_acc - acc0 < 5 && n < 100) begin
            tick();
            n++;
        end
        check_eq("w4_reached", m_acc - acc0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_valid", valid, 1'b0);
        check_eq("rst_mid_ovf", overflow, 1'b0);
        tick();
        check_eq("rst_mid_idle", valid, 1'b0);
        frame3(1'b1);
        drain("post_rst", cyc);

        // Events without pixel_valid are ignored.
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_eq("pv0_valid", valid, 1'b0);
        check_eq("pv0_ovf", overflow, 1'b0);

        // Random traffic with a random sink.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (ent_q.size() < DEPTH - 1 && $urandom_range(0, 2) == 0) begin
                send(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b1);
            end else begin
                tick();
            end
        end
        drain("random", cyc);
        rand_ready = 1'b0;
        ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
